// File: rtl/captura_jogada.sv
// Button-capture stage: debounces the raw buttons, accepts one play per physical
// press, rejects multi-button patterns and times out an idle player.
module captura_jogada #(
  parameter int DEBOUNCE_CICLOS = 3,
  parameter int TIMEOUT_CICLOS  = 5000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       zera,
  input  logic       habilita,
  input  logic [3:0] botoes,
  output logic [3:0] jogada_feita,
  output logic       jogada,
  output logic       invalida,
  output logic       tem_jogada,
  output logic       timeout,
  output logic [3:0] db_estado
);

  localparam int CW = $clog2(DEBOUNCE_CICLOS);
  localparam int TW = $clog2(TIMEOUT_CICLOS);
  localparam logic [CW-1:0] CNT_ULT   = CW'(DEBOUNCE_CICLOS - 1);
  localparam logic [TW-1:0] TIMER_ULT = TW'(TIMEOUT_CICLOS - 1);

  typedef enum logic [1:0] {
    LIVRE    = 2'd0,
    FILTRA   = 2'd1,
    REGISTRA = 2'd2,
    SOLTA    = 2'd3
  } estado_t;

  estado_t       estado_q, estado_d;
  logic [3:0]    cand_q, cand_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          timeout_q, timeout_d;
  logic [3:0]    jf_q, jf_d;
  logic          entra_reg;
  logic          cand_onehot;

  assign cand_onehot = (cand_q != 4'd0) && ((cand_q & (cand_q - 4'd1)) == 4'd0);

  always_comb begin
    estado_d  = estado_q;
    cand_d    = cand_q;
    cnt_d     = cnt_q;
    jf_d      = jf_q;
    timer_d   = timer_q;
    timeout_d = timeout_q;
    entra_reg = 1'b0;

    // cnt_q counts equal samples in FILTRA and quiet samples in SOLTA
    case (estado_q)
      LIVRE: begin
        if (habilita && !timeout_q && botoes != 4'd0) begin
          cand_d   = botoes;
          cnt_d    = CW'(1);
          estado_d = FILTRA;
        end
      end
      FILTRA: begin
        if (!habilita) begin
          estado_d = SOLTA;
          cnt_d    = '0;
        end else if (botoes == 4'd0) begin
          estado_d = LIVRE;
        end else if (botoes != cand_q) begin
          cand_d = botoes;
          cnt_d  = CW'(1);
        end else if (cnt_q == CNT_ULT) begin
          estado_d  = REGISTRA;
          entra_reg = 1'b1;
          if (cand_onehot) jf_d = cand_q;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      REGISTRA: begin
        estado_d = SOLTA;
        cnt_d    = '0;
      end
      SOLTA: begin
        if (botoes != 4'd0) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_ULT) begin
          estado_d = LIVRE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: estado_d = LIVRE;
    endcase

    // Timer saturates at its last value and raises the sticky flag instead of wrapping
    if (!habilita || entra_reg) begin
      timer_d = '0;
    end else if (!timeout_q && (estado_q == LIVRE || estado_q == FILTRA)) begin
      if (timer_q == TIMER_ULT) timeout_d = 1'b1;
      else                      timer_d   = timer_q + TW'(1);
    end

    // Parking in SOLTA makes a still-held button wait for a full release
    if (zera) begin
      jf_d      = 4'd0;
      timer_d   = '0;
      timeout_d = 1'b0;
      estado_d  = SOLTA;
      cnt_d     = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q  <= LIVRE;
      cand_q    <= 4'd0;
      cnt_q     <= '0;
      timer_q   <= '0;
      timeout_q <= 1'b0;
      jf_q      <= 4'd0;
    end else begin
      estado_q  <= estado_d;
      cand_q    <= cand_d;
      cnt_q     <= cnt_d;
      timer_q   <= timer_d;
      timeout_q <= timeout_d;
      jf_q      <= jf_d;
    end
  end

  assign jogada       = (estado_q == REGISTRA) && cand_onehot;
  assign invalida     = (estado_q == REGISTRA) && !cand_onehot;
  assign jogada_feita = jf_q;
  assign timeout      = timeout_q;
  assign tem_jogada   = |botoes;
  assign db_estado    = {2'b00, estado_q};

endmodule

// File: tb/tb_captura_jogada.sv
// Bench for captura_jogada: directed scenarios plus randomized traffic checked
// against a sample-counting reference model.
module tb_captura_jogada;

  localparam int D = 3;
  localparam int T = 20;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       zera = 1'b0;
  logic       habilita = 1'b0;
  logic [3:0] botoes = 4'd0;
  logic [3:0] jogada_feita;
  logic       jogada, invalida, tem_jogada, timeout;
  logic [3:0] db_estado;

  int checks = 0;
  int errors = 0;
  int n_jog = 0;
  int n_inv = 0;

  // Reference model: phase flags plus sample counts
  bit         m_busy, m_fire, m_to;
  int         m_run, m_quiet, m_timer;
  logic [3:0] m_cand, m_jf;

  captura_jogada #(.DEBOUNCE_CICLOS(D), .TIMEOUT_CICLOS(T)) dut (
    .clock(clock), .reset(reset), .zera(zera), .habilita(habilita),
    .botoes(botoes), .jogada_feita(jogada_feita), .jogada(jogada),
    .invalida(invalida), .tem_jogada(tem_jogada), .timeout(timeout),
    .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got running want finished");
    $fatal(1);
  end

  task automatic step(input logic [3:0] b, input logic h, input logic z, input logic r);
    bit counting, accepted;
    botoes = b; habilita = h; zera = z; reset = r;
    @(posedge clock);
    if (r) begin
      m_busy = 0; m_fire = 0; m_to = 0; m_run = 0; m_quiet = 0; m_timer = 0;
      m_cand = 4'd0; m_jf = 4'd0;
    end else begin
      accepted = 0;
      counting = h && !m_to && !m_busy && !m_fire;
      if (m_fire) begin
        m_fire = 0; m_busy = 1; m_quiet = 0;
      end else if (m_busy) begin
        m_quiet = (b == 4'd0) ? m_quiet + 1 : 0;
        if (m_quiet == D) m_busy = 0;
      end else if (m_run > 0) begin
        if (!h) begin
          m_run = 0; m_busy = 1; m_quiet = 0;
        end else if (b == 4'd0) begin
          m_run = 0;
        end else if (b != m_cand) begin
          m_cand = b; m_run = 1;
        end else begin
          m_run++;
          if (m_run == D) begin
            m_run = 0; m_fire = 1; accepted = 1;
            if ($countones(m_cand) == 1) m_jf = m_cand;
          end
        end
      end else if (h && !m_to && b != 4'd0) begin
        m_cand = b; m_run = 1;
      end
      if (!h || accepted) m_timer = 0;
      else if (counting) begin
        if (m_timer == T - 1) m_to = 1;
        else m_timer++;
      end
      if (z) begin
        m_jf = 4'd0; m_timer = 0; m_to = 0;
        m_busy = 1; m_quiet = 0; m_run = 0; m_fire = 0;
      end
    end
    #1;
    if (jogada) n_jog++;
    if (invalida) n_inv++;
  endtask

  task automatic test_reset;
    step(4'd0, 1'b0, 1'b0, 1'b1);
    step(4'd0, 1'b0, 1'b0, 1'b0);
    checks++; if (jogada_feita !== 4'd0) begin errors++; $display("FAIL reset_jf: got %b want 0000", jogada_feita); end
    checks++; if (jogada !== 1'b0 || invalida !== 1'b0) begin errors++; $display("FAIL reset_pulses: got %b%b want 00", jogada, invalida); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b want 0", timeout); end
    checks++; if (db_estado !== 4'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", db_estado); end
  endtask

  task automatic test_valid_press;
    int first;
    first = 0; n_jog = 0; n_inv = 0;
    for (int i = 1; i <= 10; i++) begin
      step(4'b0100, 1'b1, 1'b0, 1'b0);
      if (jogada && first == 0) first = i;
    end
    checks++; if (n_jog != 1) begin errors++; $display("FAIL valid_count: got %0d want 1", n_jog); end
    checks++; if (first != D) begin errors++; $display("FAIL valid_latency: got %0d want %0d", first, D); end
    checks++; if (jogada_feita !== 4'b0100) begin errors++; $display("FAIL valid_jf: got %b want 0100", jogada_feita); end
    checks++; if (db_estado !== 4'd3) begin errors++; $display("FAIL valid_hold_state: got %0d want 3", db_estado); end
    for (int i = 1; i <= D; i++) begin
      step(4'd0, 1'b1, 1'b0, 1'b0);
      checks++;
      if (db_estado !== ((i < D) ? 4'd3 : 4'd0)) begin
        errors++; $display("FAIL valid_release_%0d: got %0d want %0d", i, db_estado, (i < D) ? 3 : 0);
      end
    end
  endtask

  task automatic test_invalid;
    step(4'd0, 1'b0, 1'b0, 1'b0);
    n_jog = 0; n_inv = 0;
    repeat (10) step(4'b0011, 1'b1, 1'b0, 1'b0);
    checks++; if (n_inv != 1) begin errors++; $display("FAIL invalid_count: got %0d want 1", n_inv); end
    checks++; if (n_jog != 0) begin errors++; $display("FAIL invalid_nojog: got %0d want 0", n_jog); end
    checks++; if (jogada_feita !== 4'b0100) begin errors++; $display("FAIL invalid_jf: got %b want 0100", jogada_feita); end
    repeat (D) step(4'd0, 1'b0, 1'b0, 1'b0);
    checks++; if (db_estado !== 4'd0) begin errors++; $display("FAIL invalid_release: got %0d want 0", db_estado); end
  endtask

  task automatic test_bounce;
    n_jog = 0; n_inv = 0;
    repeat (2) step(4'b0010, 1'b1, 1'b0, 1'b0);
    step(4'd0, 1'b1, 1'b0, 1'b0);
    repeat (10) step(4'b0010, 1'b1, 1'b0, 1'b0);
    checks++; if (n_jog != 1 || n_inv != 0) begin errors++; $display("FAIL bounce_count: got jog=%0d inv=%0d want jog=1 inv=0", n_jog, n_inv); end
    checks++; if (jogada_feita !== 4'b0010) begin errors++; $display("FAIL bounce_jf: got %b want 0010", jogada_feita); end
    repeat (D) step(4'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_timeout;
    step(4'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= T; i++) begin
      step(4'd0, 1'b1, 1'b0, 1'b0);
      if (i == T - 1) begin
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL timeout_early: got %b want 0", timeout); end
      end
    end
    checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL timeout_set: got %b want 1", timeout); end
    n_jog = 0; n_inv = 0;
    repeat (5) step(4'b1000, 1'b1, 1'b0, 1'b0);
    checks++; if (n_jog != 0 || db_estado !== 4'd0) begin errors++; $display("FAIL timeout_ignore: got jog=%0d state=%0d want jog=0 state=0", n_jog, db_estado); end
    checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL timeout_sticky: got %b want 1", timeout); end
    step(4'd0, 1'b1, 1'b1, 1'b0);
    checks++; if (timeout !== 1'b0 || db_estado !== 4'd3) begin errors++; $display("FAIL timeout_zera: got to=%b state=%0d want to=0 state=3", timeout, db_estado); end
    // Three quiet samples back to LIVRE, then T counting cycles
    for (int i = 1; i <= D + T; i++) begin
      step(4'd0, 1'b1, 1'b0, 1'b0);
      if (i == D + T - 1) begin
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL timeout_restart_early: got %b want 0", timeout); end
      end
    end
    checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL timeout_restart: got %b want 1", timeout); end
    step(4'd0, 1'b0, 1'b1, 1'b0);
    repeat (D) step(4'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_zera_hold;
    n_jog = 0; n_inv = 0;
    repeat (D - 1) step(4'b0001, 1'b1, 1'b0, 1'b0);
    step(4'b0001, 1'b1, 1'b1, 1'b0);
    checks++; if (jogada_feita !== 4'd0 || jogada !== 1'b0) begin errors++; $display("FAIL zera_wins: got jf=%b jog=%b want jf=0000 jog=0", jogada_feita, jogada); end
    repeat (10) step(4'b0001, 1'b1, 1'b0, 1'b0);
    checks++; if (n_jog != 0 || db_estado !== 4'd3) begin errors++; $display("FAIL zera_held: got jog=%0d state=%0d want jog=0 state=3", n_jog, db_estado); end
    repeat (D) step(4'd0, 1'b1, 1'b0, 1'b0);
    repeat (5) step(4'b0001, 1'b1, 1'b0, 1'b0);
    checks++; if (n_jog != 1 || jogada_feita !== 4'b0001) begin errors++; $display("FAIL zera_repress: got jog=%0d jf=%b want jog=1 jf=0001", n_jog, jogada_feita); end
    repeat (D) step(4'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_filtra;
    step(4'b0100, 1'b1, 1'b0, 1'b0);
    checks++; if (db_estado !== 4'd1) begin errors++; $display("FAIL rstf_filtra: got %0d want 1", db_estado); end
    step(4'b0100, 1'b1, 1'b0, 1'b1);
    checks++; if (db_estado !== 4'd0 || jogada_feita !== 4'd0 || jogada !== 1'b0 || invalida !== 1'b0 || timeout !== 1'b0) begin
      errors++; $display("FAIL rstf_values: got state=%0d jf=%b jog=%b inv=%b to=%b want 0 0000 0 0 0", db_estado, jogada_feita, jogada, invalida, timeout);
    end
    repeat (D + 1) step(4'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_random;
    int cyc, dur, sel;
    logic [3:0] b, exp_db;
    logic h, z, r, exp_j, exp_i;
    cyc = 0;
    while (cyc < 1500) begin
      sel = $urandom_range(0, 9);
      if (sel < 4) b = 4'd0;
      else if (sel < 8) b = 4'd1 << $urandom_range(0, 3);
      else b = 4'($urandom_range(1, 15));
      h = ($urandom_range(0, 9) != 0);
      dur = $urandom_range(1, 7);
      for (int k = 0; k < dur; k++) begin
        z = ($urandom_range(0, 59) == 0);
        r = ($urandom_range(0, 299) == 0);
        step(b, h, z, r);
        cyc++;
        exp_j = m_fire && ($countones(m_cand) == 1);
        exp_i = m_fire && ($countones(m_cand) != 1);
        exp_db = m_fire ? 4'd2 : m_busy ? 4'd3 : (m_run > 0) ? 4'd1 : 4'd0;
        checks++; if (jogada !== exp_j) begin errors++; $display("FAIL rnd_jogada @%0d: got %b want %b", cyc, jogada, exp_j); end
        checks++; if (invalida !== exp_i) begin errors++; $display("FAIL rnd_invalida @%0d: got %b want %b", cyc, invalida, exp_i); end
        checks++; if (jogada_feita !== m_jf) begin errors++; $display("FAIL rnd_jf @%0d: got %b want %b", cyc, jogada_feita, m_jf); end
        checks++; if (timeout !== m_to) begin errors++; $display("FAIL rnd_timeout @%0d: got %b want %b", cyc, timeout, m_to); end
        checks++; if (db_estado !== exp_db) begin errors++; $display("FAIL rnd_state @%0d: got %0d want %0d", cyc, db_estado, exp_db); end
        checks++; if (tem_jogada !== (b != 4'd0)) begin errors++; $display("FAIL rnd_tem_jogada @%0d: got %b want %b", cyc, tem_jogada, b != 4'd0); end
      end
    end
  endtask

  initial begin
    @(negedge clock);
    test_reset;
    test_valid_press;
    test_invalid;
    test_bounce;
    test_timeout;
    test_zera_hold;
    test_reset_filtra;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
